// File: rtl/bus_dev_in_fifo_if.sv
// bus_dev_in_fifo_if: device write / bus read port bundle of the per-device input queue
`timescale 1ns/1ps
interface bus_dev_in_fifo_if #(
  parameter int PCKG_SZ = 16,
  parameter int CW = 4
);
  logic               push;
  logic [PCKG_SZ-1:0] D_push;
  logic               pop;
  logic               stat_clr;
  logic [PCKG_SZ-1:0] D_pop;
  logic               pndng;
  logic               full;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               bad_dest;
  logic [15:0]        drop_cnt;
  modport master (
    output push, D_push, pop, stat_clr,
    input  D_pop, pndng, full, count, overflow, bad_dest, drop_cnt
  );
  modport slave (
    input  push, D_push, pop, stat_clr,
    output D_pop, pndng, full, count, overflow, bad_dest, drop_cnt
  );
endinterface

// File: rtl/bus_dev_in_fifo.sv
// bus_dev_in_fifo: circular packet queue feeding one bus port, with drop and bad-destination accounting
`timescale 1ns/1ps
module bus_dev_in_fifo #(
  parameter int         PCKG_SZ   = 16,
  parameter int         FIFO_SIZE = 8,
  parameter int         DRVRS     = 16,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input logic            clk,
  input logic            reset,
  bus_dev_in_fifo_if.slave bus
);
  localparam int CW = $clog2(FIFO_SIZE + 1);
  localparam int PW = $clog2(FIFO_SIZE);
  localparam logic [7:0] DRV = 8'(DRVRS);
  logic [PCKG_SZ-1:0] r_mem [FIFO_SIZE];
  logic [PW-1:0]      r_rd, r_wr;
  logic [CW-1:0]      r_count, w_count;
  logic               r_pndng, r_full, r_ovf, r_bad;
  logic [15:0]        r_drop;
  logic               w_push, w_pop, w_drop, w_bad;
  logic [7:0]         w_dest;
  // A full queue still accepts a push when the bus pops in the same cycle.
  always_comb begin
    w_dest  = bus.D_push[PCKG_SZ-1 -: 8];
    w_pop   = bus.pop && r_pndng;
    w_push  = bus.push && (!r_full || bus.pop);
    w_drop  = bus.push && r_full && !bus.pop;
    w_bad   = w_push && w_dest >= DRV && w_dest != BROADCAST;
    w_count = r_count + CW'(w_push) - CW'(w_pop);
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= bus.D_push;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_pndng <= 1'b0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_bad   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_rd    <= w_pop ? (r_rd == PW'(FIFO_SIZE - 1) ? '0 : r_rd + PW'(1)) : r_rd;
      r_wr    <= w_push ? (r_wr == PW'(FIFO_SIZE - 1) ? '0 : r_wr + PW'(1)) : r_wr;
      r_count <= w_count;
      r_pndng <= w_count != '0;
      r_full  <= w_count == CW'(FIFO_SIZE);
      r_ovf   <= w_drop || (r_ovf && !bus.stat_clr);
      r_bad   <= w_bad || (r_bad && !bus.stat_clr);
      r_drop  <= bus.stat_clr ? 16'(w_drop) : (w_drop && r_drop != 16'hFFFF) ? r_drop + 16'd1 : r_drop;
    end
  end
  assign bus.D_pop    = r_pndng ? r_mem[r_rd] : '0;
  assign bus.pndng    = r_pndng;
  assign bus.full     = r_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
  assign bus.bad_dest = r_bad;
  assign bus.drop_cnt = r_drop;
endmodule

// File: tb/tb_bus_dev_in_fifo.sv
// tb_bus_dev_in_fifo: directed checks of reset, ordering, full/drop, wrap and status flags
`timescale 1ns/1ps
module tb_bus_dev_in_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bus_dev_in_fifo_if bus ();
  bus_dev_in_fifo dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_pndng"}, 32'(bus.pndng), 0);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    chk({tag, "_bad"}, 32'(bus.bad_dest), 0);
    chk({tag, "_drop"}, 32'(bus.drop_cnt), 0);
    chk({tag, "_dpop"}, 32'(bus.D_pop), 0);
  endtask
  task automatic step(input logic p, input logic [15:0] d, input logic q, input logic c);
    bus.push = p;
    bus.D_push = d;
    bus.pop = q;
    bus.stat_clr = c;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.D_push = '0;
    bus.pop = 1'b0;
    bus.stat_clr = 1'b0;
  endtask
  initial begin
    bus.push = 1'b0;
    bus.D_push = '0;
    bus.pop = 1'b0;
    bus.stat_clr = 1'b0;
    #12;
    chk_idle("por");
    reset = 1'b1;
    @(posedge clk);
    #1;
    // T1: asynchronous reset mid-cycle with packets queued
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    chk("t1_count3", 32'(bus.count), 3);
    chk("t1_head", 32'(bus.D_pop), 32'h0100);
    #3 reset = 1'b0;
    #1 chk_idle("t1_async");
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("t1_after");
    // T2: order and one-cycle write latency
    step(1'b1, 16'h0312, 1'b0, 1'b0);
    chk("t2_pndng", 32'(bus.pndng), 1);
    chk("t2_first", 32'(bus.D_pop), 32'h0312);
    step(1'b1, 16'h0534, 1'b0, 1'b0);
    step(1'b1, 16'h0756, 1'b0, 1'b0);
    chk("t2_count", 32'(bus.count), 3);
    chk("t2_head", 32'(bus.D_pop), 32'h0312);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t2_pop1", 32'(bus.D_pop), 32'h0534);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t2_pop2", 32'(bus.D_pop), 32'h0756);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t2_pop3", 32'(bus.D_pop), 0);
    chk("t2_empty", 32'(bus.pndng), 0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t2_pop_empty_count", 32'(bus.count), 0);
    chk("t2_pop_empty_ovf", 32'(bus.overflow), 0);
    // T3: fill beyond depth, two drops
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
      if (i == 6) chk("t3_not_full7", 32'(bus.full), 0);
      if (i == 7) chk("t3_full8", 32'(bus.full), 1);
      if (i == 7) chk("t3_ovf_before", 32'(bus.overflow), 0);
    end
    chk("t3_count", 32'(bus.count), 8);
    chk("t3_ovf", 32'(bus.overflow), 1);
    chk("t3_drop", 32'(bus.drop_cnt), 2);
    for (int i = 0; i < 8; i++) begin
      chk("t3_data", 32'(bus.D_pop), 32'h0100 + i);
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    chk("t3_drained", 32'(bus.pndng), 0);
    chk("t3_full_clr", 32'(bus.full), 0);
    // T4: push+pop while full
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    chk("t4_full", 32'(bus.full), 1);
    step(1'b1, 16'h0AAA, 1'b1, 1'b0);
    chk("t4_count", 32'(bus.count), 8);
    chk("t4_full_hold", 32'(bus.full), 1);
    chk("t4_nodrop", 32'(bus.drop_cnt), 2);
    for (int i = 0; i < 8; i++) begin
      chk("t4_data", 32'(bus.D_pop), i < 7 ? 32'h0201 + i : 32'h0AAA);
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    chk("t4_empty", 32'(bus.pndng), 0);
    // T5: sustained push+pop at count 3 across pointer wraps
    step(1'b1, 16'h0300, 1'b1, 1'b0);
    chk("t5_empty_pushpop", 32'(bus.count), 1);
    step(1'b1, 16'h0301, 1'b0, 1'b0);
    step(1'b1, 16'h0302, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("t5_data", 32'(bus.D_pop), 32'h0300 + i);
      step(1'b1, 16'h0303 + 16'(i), 1'b1, 1'b0);
      chk("t5_count", 32'(bus.count), 3);
    end
    for (int i = 0; i < 3; i++) begin
      chk("t5_tail", 32'(bus.D_pop), 32'h0314 + i);
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    chk("t5_empty", 32'(bus.count), 0);
    // T6: destination check and status clear
    step(1'b1, 16'hFF00, 1'b0, 1'b0);
    chk("t6_bcast", 32'(bus.bad_dest), 0);
    step(1'b1, 16'h0F00, 1'b0, 1'b0);
    chk("t6_dest15", 32'(bus.bad_dest), 0);
    step(1'b1, 16'h1100, 1'b0, 1'b0);
    chk("t6_dest11", 32'(bus.bad_dest), 1);
    chk("t6_stored", 32'(bus.count), 3);
    step(1'b1, 16'hFF00, 1'b0, 1'b0);
    chk("t6_sticky", 32'(bus.bad_dest), 1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t6_clr_bad", 32'(bus.bad_dest), 0);
    chk("t6_clr_drop", 32'(bus.drop_cnt), 0);
    chk("t6_clr_ovf", 32'(bus.overflow), 0);
    chk("t6_clr_count", 32'(bus.count), 4);
    step(1'b1, 16'h1000, 1'b0, 1'b1);
    chk("t6_set_wins_bad", 32'(bus.bad_dest), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
    chk("t6_full", 32'(bus.full), 1);
    step(1'b1, 16'h0500, 1'b0, 1'b1);
    chk("t6_set_wins_drop", 32'(bus.drop_cnt), 1);
    chk("t6_set_wins_ovf", 32'(bus.overflow), 1);
    chk("t6_clr_bad2", 32'(bus.bad_dest), 0);
    chk("t6_head", 32'(bus.D_pop), 32'hFF00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
